// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA sprite engine: register map constants,
// sprite geometry, the RRRGGGBB colour type, the per-sprite register
// bundle and a span-test helper used by the hit logic.
// No ports (package).
// -----------------------------------------------------------------------------
package vga_pkg;

    localparam int MAX_SPRITES = 4;   // register map is always sized for 4
    localparam int SPRITE_SIZE = 16;  // sprites are 16x16 pixels

    // Field offsets within a sprite's 4-word register block (base 4*i)
    localparam logic [1:0] SPR_X    = 2'd0;
    localparam logic [1:0] SPR_Y    = 2'd1;
    localparam logic [1:0] SPR_CTRL = 2'd2;

    localparam logic [4:0] COLLISION_ADDR = 5'd16;
    localparam logic [4:0] BG_ADDR        = 5'd17;

    typedef logic [7:0] colour_t;  // RRRGGGBB

    typedef struct packed {
        logic       enable;
        colour_t    colour;
        logic [9:0] y;
        logic [9:0] x;
    } sprite_regs_t;

    // True when coord lies in [base, base+16). Done in 11 bits so a sprite
    // near the right/bottom edge is clipped instead of wrapping to 0.
    function automatic logic in_span(input logic [9:0] coord, input logic [9:0] base);
        logic [10:0] c;
        logic [10:0] lo;
        c  = {1'b0, coord};
        lo = {1'b0, base};
        return (c >= lo) && (c < lo + 11'(SPRITE_SIZE));
    endfunction

endpackage

// File: rtl/sprite_bitmap_ram.sv
// -----------------------------------------------------------------------------
// sprite_bitmap_ram
// 16 rows x 16 bits bitmap store for one sprite. One write port, one
// synchronous read port (row appears one cycle after i_raddr).
// Ports:
//   i_clk    pixel clock
//   i_we     row write strobe
//   i_waddr  row to write
//   i_wdata  row pattern, bit 15 = leftmost pixel
//   i_raddr  row to read
//   o_rdata  registered read data
// -----------------------------------------------------------------------------
module sprite_bitmap_ram (
    input  logic        i_clk,
    input  logic        i_we,
    input  logic [3:0]  i_waddr,
    input  logic [15:0] i_wdata,
    input  logic [3:0]  i_raddr,
    output logic [15:0] o_rdata
);

    logic [15:0] r_mem [16];
    logic [15:0] r_rdata;

    // NOTE: the array has no reset so it can map onto RAM; contents are
    // undefined until software writes them.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/vga_sprite_engine.sv
// -----------------------------------------------------------------------------
// vga_sprite_engine
// Pixel stage behind the VGA timing generator. Composites up to NUM_SPRITES
// 16x16 one-bit sprites over a background colour with a 2-cycle pipeline;
// syncs are delayed to match. Sprite/background registers are written into
// shadow copies and loaded into the active set on the cycle after the rising
// edge of in_vblank, so a frame never tears.
// Optional feature: define SPRITE_COLLISION_EN to enable sticky collision
// detection at address 16 (otherwise address 16 reads 0).
// Ports:
//   i_clk, i_reset               pixel clock, synchronous active-high reset
//   i_x_coord, i_y_coord         current coordinate
//   i_in_visible_region          coordinate is displayed
//   i_in_vblank                  vertical blanking
//   i_hsync, i_vsync             raw syncs (active low)
//   o_hsync, o_vsync             syncs delayed 2 cycles
//   o_red, o_green, o_blue       pixel colour (3/3/2 bits)
//   i_reg_we/addr/wdata          register write port
//   o_reg_rdata                  register read data, 1 cycle after address
//   i_bmp_we/sprite/row/data     bitmap row write port
// -----------------------------------------------------------------------------
module vga_sprite_engine
    import vga_pkg::*;
#(
    parameter int NUM_SPRITES = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [9:0]  i_x_coord,
    input  logic [9:0]  i_y_coord,
    input  logic        i_in_visible_region,
    input  logic        i_in_vblank,
    input  logic        i_hsync,
    input  logic        i_vsync,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic [2:0]  o_red,
    output logic [2:0]  o_green,
    output logic [1:0]  o_blue,
    input  logic        i_reg_we,
    input  logic [4:0]  i_reg_addr,
    input  logic [15:0] i_reg_wdata,
    output logic [15:0] o_reg_rdata,
    input  logic        i_bmp_we,
    input  logic [1:0]  i_bmp_sprite,
    input  logic [3:0]  i_bmp_row,
    input  logic [15:0] i_bmp_data
);

    // ---------------------------------------------------------------- registers
    sprite_regs_t r_shadow [MAX_SPRITES];
    sprite_regs_t r_active [MAX_SPRITES];
    colour_t      r_shadow_bg;
    colour_t      r_active_bg;
    logic         r_vblank_prev;
    logic         r_copy;        // high during the shadow->active copy cycle
    logic [15:0]  r_rdata;

    logic [1:0]   w_reg_idx;
    logic [1:0]   w_reg_field;
    logic         w_spr_wr;
    logic         w_unused_wdata;

    assign w_reg_idx      = i_reg_addr[3:2];
    assign w_reg_field    = i_reg_addr[1:0];
    assign w_spr_wr       = i_reg_we && !i_reg_addr[4] && (int'(w_reg_idx) < NUM_SPRITES);
    assign w_unused_wdata = ^i_reg_wdata[15:10];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int s = 0; s < MAX_SPRITES; s++) begin
                r_shadow[s] <= '0;
                r_active[s] <= '0;
            end
            r_shadow_bg   <= '0;
            r_active_bg   <= '0;
            r_vblank_prev <= 1'b0;
            r_copy        <= 1'b0;
        end else begin
            r_vblank_prev <= i_in_vblank;
            r_copy        <= i_in_vblank && !r_vblank_prev;
            // Copy takes the shadow value from before any same-cycle write,
            // so a write in the copy cycle waits for the next vblank.
            if (r_copy) begin
                r_active    <= r_shadow;
                r_active_bg <= r_shadow_bg;
            end
            if (w_spr_wr) begin
                case (w_reg_field)
                    SPR_X:    r_shadow[w_reg_idx].x <= i_reg_wdata[9:0];
                    SPR_Y:    r_shadow[w_reg_idx].y <= i_reg_wdata[9:0];
                    SPR_CTRL: begin
                        r_shadow[w_reg_idx].enable <= i_reg_wdata[8];
                        r_shadow[w_reg_idx].colour <= i_reg_wdata[7:0];
                    end
                    default: ;
                endcase
            end
            if (i_reg_we && i_reg_addr == BG_ADDR) begin
                r_shadow_bg <= i_reg_wdata[7:0];
            end
        end
    end

    // ---------------------------------------------------------------- stage 0
    logic [MAX_SPRITES-1:0] w_hit;
    logic [3:0]             w_dx [MAX_SPRITES];
    logic [3:0]             w_dy [MAX_SPRITES];
    logic [15:0]            w_row [MAX_SPRITES];

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_hit = '0;
        for (int s = 0; s < MAX_SPRITES; s++) begin
            w_dx[s]  = i_x_coord[3:0] - r_active[s].x[3:0];
            w_dy[s]  = i_y_coord[3:0] - r_active[s].y[3:0];
            w_hit[s] = r_active[s].enable
                       && in_span(i_x_coord, r_active[s].x)
                       && in_span(i_y_coord, r_active[s].y);
        end
    end

    for (genvar s = 0; s < MAX_SPRITES; s++) begin : g_spr
        if (s < NUM_SPRITES) begin : g_ram
            sprite_bitmap_ram u_ram (
                .i_clk   (i_clk),
                .i_we    (i_bmp_we && (i_bmp_sprite == 2'(s))),
                .i_waddr (i_bmp_row),
                .i_wdata (i_bmp_data),
                .i_raddr (w_dy[s]),
                .o_rdata (w_row[s])
            );
        end else begin : g_none
            assign w_row[s] = '0;
        end
    end

    logic [MAX_SPRITES-1:0] r_s1_hit;
    logic [3:0]             r_s1_dx [MAX_SPRITES];
    logic                   r_s1_vis;
    logic                   r_hs_d1, r_vs_d1, r_hs_d2, r_vs_d2;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_s1_hit <= '0;
            for (int s = 0; s < MAX_SPRITES; s++) begin
                r_s1_dx[s] <= '0;
            end
            r_s1_vis <= 1'b0;
            r_hs_d1  <= 1'b1;
            r_vs_d1  <= 1'b1;
            r_hs_d2  <= 1'b1;
            r_vs_d2  <= 1'b1;
        end else begin
            r_s1_hit <= w_hit;
            r_s1_dx  <= w_dx;
            r_s1_vis <= i_in_visible_region;
            r_hs_d1  <= i_hsync;
            r_vs_d1  <= i_vsync;
            r_hs_d2  <= r_hs_d1;
            r_vs_d2  <= r_vs_d1;
        end
    end

    // ---------------------------------------------------------------- stage 1
    logic [MAX_SPRITES-1:0] w_opaque;
    colour_t                w_pixel;

    always_comb begin
        w_opaque = '0;
        w_pixel  = r_active_bg;
        for (int s = 0; s < MAX_SPRITES; s++) begin
            w_opaque[s] = r_s1_hit[s] && w_row[s][4'd15 - r_s1_dx[s]];
        end
        // Walk from the highest index down so the lowest opaque index wins.
        for (int s = MAX_SPRITES - 1; s >= 0; s--) begin
            if (w_opaque[s]) begin
                w_pixel = r_active[s].colour;
            end
        end
    end

    colour_t r_colour;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_colour <= '0;
        end else begin
            r_colour <= r_s1_vis ? w_pixel : '0;
        end
    end

    // ---------------------------------------------------------------- collision
    logic [15:0] w_collision_word;

`ifdef SPRITE_COLLISION_EN
    logic                   r_coll_flag;
    logic [MAX_SPRITES-1:0] r_coll_mask;
    logic                   w_coll_set;
    logic                   w_coll_clr;

    assign w_coll_set = r_s1_vis && ($countones(w_opaque) >= 2);
    assign w_coll_clr = i_reg_we && (i_reg_addr == COLLISION_ADDR);

    // Sticky; a set in the same cycle as a clear-write wins.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_coll_flag <= 1'b0;
            r_coll_mask <= '0;
        end else if (w_coll_set) begin
            r_coll_flag <= 1'b1;
            r_coll_mask <= (w_coll_clr ? '0 : r_coll_mask) | w_opaque;
        end else if (w_coll_clr) begin
            r_coll_flag <= 1'b0;
            r_coll_mask <= '0;
        end
    end

    assign w_collision_word = {8'b0, r_coll_mask, 3'b0, r_coll_flag};
`else
    assign w_collision_word = '0;
`endif

    // ---------------------------------------------------------------- readback
    logic [15:0] w_rdata;

    always_comb begin
        w_rdata = '0;
        if (!i_reg_addr[4]) begin
            case (w_reg_field)
                SPR_X:    w_rdata = {6'b0, r_shadow[w_reg_idx].x};
                SPR_Y:    w_rdata = {6'b0, r_shadow[w_reg_idx].y};
                SPR_CTRL: w_rdata = {7'b0, r_shadow[w_reg_idx].enable, r_shadow[w_reg_idx].colour};
                default:  w_rdata = '0;
            endcase
        end else if (i_reg_addr == COLLISION_ADDR) begin
            w_rdata = w_collision_word;
        end else if (i_reg_addr == BG_ADDR) begin
            w_rdata = {8'b0, r_shadow_bg};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= w_rdata;
        end
    end

    assign o_reg_rdata = r_rdata;
    assign o_red       = r_colour[7:5];
    assign o_green     = r_colour[4:2];
    assign o_blue      = r_colour[1:0];
    assign o_hsync     = r_hs_d2;
    assign o_vsync     = r_vs_d2;

endmodule
